// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-masked dual-port RAM.
// Used by dpram_be_sync and dpram_init_ctrl.
package dpram_pkg;

    typedef enum logic {
        INIT,
        READY
    } state_e;

    localparam logic [31:0] DEFAULT_INIT_VALUE = 32'h0;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/dpram_init_ctrl.sv
// Post-reset clear sequencer: walks every address once, then
// holds READY until the next reset.
module dpram_init_ctrl
    import dpram_pkg::*;
#(
    parameter int VECTOR_LENGTH = 512,
    parameter int ADDR_WIDTH    = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  init_done,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST =
        ADDR_WIDTH'(VECTOR_LENGTH - 1);

    state_e                state;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (cnt == LAST) begin
                        state     <= READY;
                        init_done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
            endcase
        end
    end

    assign clr_we   = (state == INIT);
    assign clr_addr = cnt;

endmodule

// File: rtl/dpram_be_sync.sv
// Single-clock simple dual-port RAM with byte-masked writes and
// post-reset clear. DPRAM_OUT_REG_EN adds a second read stage.
module dpram_be_sync
    import dpram_pkg::*;
#(
    parameter int VECTOR_LENGTH = 512,
    parameter int WORD_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 9,
    parameter bit BYPASS        = 1'b1,
    parameter logic [WORD_WIDTH-1:0] INIT_VALUE =
        WORD_WIDTH'(DEFAULT_INIT_VALUE)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    init_done_o,
    input  logic                    re_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_i,
    output logic [WORD_WIDTH-1:0]   rdata_o,
    output logic                    rvalid_o,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_i,
    input  logic [WORD_WIDTH-1:0]   wdata_i,
    input  logic [WORD_WIDTH/8-1:0] wbytemask_i
);

    localparam int NB = bytes_of(WORD_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH =
        (ADDR_WIDTH + 1)'(VECTOR_LENGTH);

    if ((WORD_WIDTH % 8) != 0 || WORD_WIDTH == 0) begin : g_bad_width
        $error("WORD_WIDTH must be a non-zero multiple of 8");
    end
    if (VECTOR_LENGTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
        $error("VECTOR_LENGTH exceeds 2**ADDR_WIDTH");
    end

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    dpram_init_ctrl #(
        .VECTOR_LENGTH(VECTOR_LENGTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_init_ctrl (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .init_done(init_done_o),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    logic [WORD_WIDTH-1:0] mem [VECTOR_LENGTH];

    logic                  ready;
    logic                  w_in_range;
    logic                  r_in_range;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WORD_WIDTH-1:0] wr_data;
    logic [NB-1:0]         wr_mask;

    assign ready      = init_done_o;
    assign w_in_range = {1'b0, waddr_i} < DEPTH;
    assign r_in_range = {1'b0, raddr_i} < DEPTH;

    // The clear sequencer owns the write port until it finishes.
    assign wr_en   = clr_we | (ready & we_i & w_in_range);
    assign wr_addr = clr_we ? clr_addr : waddr_i;
    assign wr_data = clr_we ? INIT_VALUE : wdata_i;
    assign wr_mask = clr_we ? {NB{1'b1}} : wbytemask_i;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_mask[k]) begin
                    mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    logic                  rd_en;
    logic                  hit;
    logic [WORD_WIDTH-1:0] old_word;
    logic [WORD_WIDTH-1:0] rd_word;

    assign rd_en    = ready & re_i;
    assign hit      = BYPASS && we_i && (waddr_i == raddr_i);
    assign old_word = r_in_range ? mem[raddr_i] : '0;

    always_comb begin
        rd_word = old_word;
        if (hit && r_in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (wbytemask_i[k]) begin
                    rd_word[8*k +: 8] = wdata_i[8*k +: 8];
                end
            end
        end
    end

    logic [WORD_WIDTH-1:0] rdata_q;
    logic                  rvalid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= rd_word;
            end
        end
    end

`ifdef DPRAM_OUT_REG_EN
    logic [WORD_WIDTH-1:0] rdata_q2;
    logic                  rvalid_q2;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q2  <= '0;
            rvalid_q2 <= 1'b0;
        end else begin
            rdata_q2  <= rdata_q;
            rvalid_q2 <= rvalid_q;
        end
    end

    assign rdata_o  = rdata_q2;
    assign rvalid_o = rvalid_q2;
`else
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
`endif

endmodule
